apb_regfile_slave: RTL
======================

Name: apb_regfile_slave

Overview:
APB completer that owns a small memory-mapped register file and serves transfers from the existing APB requester on the shared pclk bus.
- Inserts a fixed, parameterised number of wait states per transfer.
- Flags out-of-range addresses and illegal writes with pslverr.
- Register 0 is a read-only ID word, used by bench and software for bus sanity checks.

Parameters:
addrwidth, 16, width of paddr
datawidth, 16, width of pwdata/prdata and of each register
NREGS, 16, number of registers; valid indices 0..NREGS-1 (NREGS >= 2)
WAIT_CYCLES, 1, access-phase cycles with pready low before the completing cycle (0..15)
ID_VALUE, 16'hA5B0, constant returned by register 0

Ports:
pclk  input  1  bus clock; all logic on rising edge
preset  input  1  reset, synchronous, active-high
psel  input  1  completer select
penable  input  1  access-phase indicator
paddr  input  addrwidth  register index (word index, not byte address)
pwrite  input  1  1 = write, 0 = read
pwdata  input  datawidth  write data
prdata  output  datawidth  read data; valid only while pready=1
pready  output  1  transfer completes in this cycle
pslverr  output  1  error response; valid only while pready=1

Behaviour:
- Reset (preset=1 at a clock edge):
  - prdata=0, pready=0, pslverr=0; FSM to IDLE; wait counter 0.
  - Registers 1..NREGS-1 cleared to 0.
  - Applies mid-transfer too: the transfer is dropped and no write commits.
- All outputs are registered. Outside the completing cycle, prdata=0 and pslverr=0.
- FSM states:
  - IDLE: on an edge where psel=1 and penable=0 (setup phase):
    - capture paddr, pwrite, pwdata.
    - load cnt=WAIT_CYCLES.
    - go to ACCESS.
    - If WAIT_CYCLES=0, assert pready at the same edge.
  - ACCESS, each edge:
    - If psel=0 or penable=0: protocol abort. Go to IDLE, pready=0, no write.
    - Else if cnt>1: cnt-1.
    - Else if cnt==1: set pready=1 plus prdata/pslverr for the next cycle; go to RESP.
  - RESP (pready=1 this cycle):
    - At the edge, commit the write if legal, then clear pready/pslverr/prdata.
    - If psel=1 and penable=0 at this edge, treat it as a new setup (back-to-back). Otherwise go to IDLE.
  - With WAIT_CYCLES=0, the FSM goes IDLE->RESP directly at the setup edge.
- Timing:
  - Transfer length = 1 setup + WAIT_CYCLES + 1 completing cycle = WAIT_CYCLES+2 cycles.
  - The requester must hold psel/penable/paddr/pwrite/pwdata stable until pready. Captured values are used regardless.
- Decode (computed from captured address):
  - idx >= NREGS: pslverr=1, prdata=0, no write.
  - idx==0, read: prdata=ID_VALUE, pslverr=0.
  - idx==0, write: pslverr=1; the register is unchanged.
  - Otherwise read: prdata=reg[idx], pslverr=0. Write: reg[idx]<=captured pwdata at the edge ending the pready cycle.
- Read data reflects register contents as of the edge that raises pready. A write completing in the previous transfer is visible.
- Ignored inputs:
  - penable=1 while in IDLE is ignored; no setup is seen.
  - psel=0 in IDLE causes no state change.
- Only one transfer is outstanding at a time. No internal pipelining.

Test Plan:
1. Reset: hold preset=1 for 2 cycles -> prdata=0, pready=0, pslverr=0. Read idx 5 -> 16'h0000; read idx 0 -> 16'hA5B0.
2. Write then read, WAIT_CYCLES=1: write idx 5 = 16'h0001 -> pready high exactly in the 3rd cycle after setup start, pslverr=0. Read idx 5 -> prdata=16'h0001 in the pready cycle.
3. Wait-state sweep, WAIT_CYCLES=0 and 3: pready observed in cycles 2 and 5 of the transfer respectively. Transfers with WAIT_CYCLES=0 are back-to-back: write idx 3 = 16'h1234, then read idx 3 -> 16'h1234 with no idle cycle between.
4. Errors:
   - Write idx 16 (NREGS=16) = 16'hFFFF -> pslverr=1, prdata=0.
   - Write idx 0 = 16'h0000 -> pslverr=1; a later read of idx 0 still returns 16'hA5B0.
   - A read of an out-of-range idx -> pslverr=1.
5. Abort and reset mid-transfer:
   - Write idx 7 = 16'hBEEF, drop penable during the wait state -> no pready; a read of idx 7 returns 16'h0000.
   - Write idx 7 again with preset=1 asserted in the access phase -> outputs 0 next cycle; idx 7 stays 16'h0000.

Source files
------------

// File: rtl/apb_regfile_slave.sv
// APB completer over a register file (reg 0 = read-only ID); fixed WAIT_CYCLES wait states, transfer = WAIT_CYCLES+2 cycles.
// No backpressure beyond pready; one transfer outstanding, registered outputs, protocol aborts drop the transfer.
module apb_regfile_slave #(
  parameter int                   addrwidth   = 16,
  parameter int                   datawidth   = 16,
  parameter int                   NREGS       = 16,
  parameter int                   WAIT_CYCLES = 1,
  parameter logic [datawidth-1:0] ID_VALUE    = 16'hA5B0
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 psel,
  input  logic                 penable,
  input  logic [addrwidth-1:0] paddr,
  input  logic                 pwrite,
  input  logic [datawidth-1:0] pwdata,
  output logic [datawidth-1:0] prdata,
  output logic                 pready,
  output logic                 pslverr
);

  localparam int IW = $clog2(NREGS);
  localparam logic [addrwidth-1:0] NREGS_A = addrwidth'(NREGS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [addrwidth-1:0]   addr_q, addr_d;
  logic                   write_q, write_d;
  logic [datawidth-1:0]   wdata_q, wdata_d;
  logic [datawidth-1:0]   prdata_q, prdata_d;
  logic                   pready_q, pready_d;
  logic                   pslverr_q, pslverr_d;
  logic [datawidth-1:0]   regs_q [NREGS];
  logic [datawidth-1:0]   regs_d [NREGS];

  logic                   setup, complete, commit;
  logic [addrwidth-1:0]   dec_addr;
  logic                   dec_write;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    regs_d    = regs_q;
    setup     = 1'b0;
    complete  = 1'b0;
    dec_addr  = paddr;
    dec_write = pwrite;

    // The write lands at the edge ending the pready cycle.
    commit = (state_q == RESP) && write_q && (addr_q < NREGS_A) && (addr_q != '0);
    if (commit) begin
      regs_d[addr_q[IW-1:0]] = wdata_q;
    end

    case (state_q)
      IDLE: setup = psel && !penable;
      ACCESS: begin
        if (!psel || !penable) begin
          state_d = IDLE;
        end else if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        setup = psel && !penable;
        if (!setup) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (setup) begin
      addr_d  = paddr;
      write_d = pwrite;
      wdata_d = pwdata;
      cnt_d   = 4'(WAIT_CYCLES);
      if (WAIT_CYCLES == 0) begin
        complete = 1'b1;
        state_d  = RESP;
      end else begin
        state_d  = ACCESS;
      end
    end

    // Zero wait states decode the live bus; otherwise the captured request.
    if (complete) begin
      if (state_q == ACCESS) begin
        dec_addr  = addr_q;
        dec_write = write_q;
      end
      pready_d = 1'b1;
      if (dec_addr >= NREGS_A) begin
        pslverr_d = 1'b1;
      end else if (dec_addr == '0) begin
        if (dec_write) begin
          pslverr_d = 1'b1;
        end else begin
          prdata_d = ID_VALUE;
        end
      end else if (!dec_write) begin
        prdata_d = regs_d[dec_addr[IW-1:0]];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      regs_q    <= regs_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule
